// File: rtl/text_writer.sv
// text_writer: clears the text RAM, then writes incoming characters at the cursor and advances it
module text_writer #(
    parameter int char_width   = 7,
    parameter int num_cols     = 128,
    parameter int num_rows     = 48,
    parameter int newline_code = 10,
    parameter int blank_code   = 0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [char_width-1:0]                  c_in,
    input  logic                                   c_valid,
    output logic                                   c_ready,
    output logic                                   wr_en,
    output logic [$clog2(num_cols*num_rows)-1:0]   wr_addr,
    output logic [char_width-1:0]                  wr_data,
    output logic [$clog2(num_cols)-1:0]            cursor_col,
    output logic [$clog2(num_rows)-1:0]            cursor_row,
    output logic                                   busy
);
    localparam int aw = $clog2(num_cols*num_rows);
    localparam int cw = $clog2(num_cols);
    localparam int rw = $clog2(num_rows);
    localparam logic [0:0] s_clear  = 1'b0;
    localparam logic [0:0] s_accept = 1'b1;
    localparam logic [aw:0] total = (aw+1)'(num_cols*num_rows);
    localparam logic [cw-1:0] last_col = cw'(num_cols-1);
    localparam logic [rw-1:0] last_row = rw'(num_rows-1);
    localparam logic [char_width-1:0] nl = char_width'(newline_code);
    localparam logic [char_width-1:0] blank = char_width'(blank_code);

    logic [0:0]            state_q, state_d;
    logic [aw:0]           cnt_q, cnt_d;
    logic [cw-1:0]         col_q, col_d;
    logic [rw-1:0]         row_q, row_d;
    logic                  wr_en_q, wr_en_d;
    logic [aw-1:0]         wr_addr_q, wr_addr_d;
    logic [char_width-1:0] wr_data_q, wr_data_d;
    logic [aw-1:0]         cur_addr;
    logic                  is_nl, line_end;

    assign cur_addr = aw'(row_q) * aw'(num_cols) + aw'(col_q);
    assign is_nl    = c_in == nl;
    assign line_end = is_nl || col_q == last_col;

    // Next state: sweep blanks over the whole RAM, then accept characters and move the cursor
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (state_q == s_clear) begin
            state_d   = cnt_q == total ? s_accept : s_clear;
            wr_en_d   = cnt_q != total;
            wr_addr_d = cnt_q == total ? wr_addr_q : cnt_q[aw-1:0];
            wr_data_d = cnt_q == total ? wr_data_q : blank;
            cnt_d     = cnt_q == total ? '0 : cnt_q + 1'b1;
            col_d     = '0;
            row_d     = '0;
        end else if (c_valid) begin
            wr_en_d   = !is_nl;
            wr_addr_d = is_nl ? wr_addr_q : cur_addr;
            wr_data_d = is_nl ? wr_data_q : c_in;
            col_d     = line_end ? '0 : col_q + 1'b1;
            row_d     = line_end ? (row_q == last_row ? '0 : row_q + 1'b1) : row_q;
        end
    end

    // State and registered write port; reset restarts the clear and drops any pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= s_clear;
            cnt_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= blank;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign c_ready    = state_q == s_accept;
    assign busy       = state_q == s_clear;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
endmodule

// File: doc/text_writer.md
TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 SHALL have parameter char_width, default 7, giving the bit width of one character code.
REQ-002 SHALL have parameter num_cols, default 128, giving the text columns per row (1024 px / 8 px glyph).
REQ-003 SHALL have parameter num_rows, default 48, giving the text rows per screen (768 px / 16 px glyph).
REQ-004 SHALL have parameter newline_code, default 10, giving the character code that forces a line break.
REQ-005 SHALL have parameter blank_code, default 0, giving the character code written during screen clear.
REQ-006 SHALL define localparam aw = clog2(num_cols*num_rows) as the text RAM address width.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port c_in, input, char_width bits: the incoming character from a character generator.
REQ-010 SHALL have port c_valid, input, 1 bit: c_in holds a character.
REQ-011 SHALL have port c_ready, output, 1 bit: block accepts c_in this cycle.
REQ-012 SHALL have port wr_en, output, 1 bit: text RAM write strobe.
REQ-013 SHALL have port wr_addr, output, aw bits: text RAM address = row*num_cols + col.
REQ-014 SHALL have port wr_data, output, char_width bits: text RAM write data.
REQ-015 SHALL have port cursor_col, output, clog2(num_cols) bits: current cursor column.
REQ-016 SHALL have port cursor_row, output, clog2(num_rows) bits: current cursor row.
REQ-017 SHALL have port busy, output, 1 bit: high while clearing.

Function
REQ-018 SHALL implement an FSM with exactly two states: CLEAR and ACCEPT.
REQ-019 In CLEAR: write blank_code to addresses 0 .. num_cols*num_rows-1 in ascending order, one per cycle, with wr_en=1, c_ready=0, busy=1.
REQ-020 CLEAR SHALL last exactly num_cols*num_rows write cycles, then go to ACCEPT on the next edge with cursor at (0,0).
REQ-021 In ACCEPT: c_ready=1 and busy=0.
REQ-022 A transfer occurs when c_valid and c_ready are both 1 at a rising edge; c_in is ignored otherwise.
REQ-023 Printable transfer (c_in != newline_code): on the cycle after the transfer, wr_en=1, wr_addr = pre-transfer cursor address, wr_data = c_in; latency exactly 1 cycle.
REQ-024 Printable advance: col+1; if col == num_cols-1, col=0 and row+1; if row also == num_rows-1, row wraps to 0.
REQ-025 Newline transfer: no write (wr_en=0 on the following cycle); col=0 and row+1, with row num_rows-1 wrapping to 0.
REQ-026 Back-to-back transfers on consecutive cycles SHALL each produce one write (or none for newline), with no bubbles or drops.
REQ-027 wr_en SHALL be 0 in every ACCEPT cycle not following a printable transfer.
REQ-028 wr_addr arithmetic SHALL be at least aw bits wide, so that no address aliases for any in-range row/col.
REQ-029 cursor_col and cursor_row SHALL be registered and reflect the post-advance position one cycle after each transfer.

Reset
REQ-030 While reset=1 at a rising edge: state=CLEAR, clear counter=0, cursor=(0,0), and any pending write is cancelled.
REQ-031 Output values during and after reset: wr_en=0, c_ready=0, busy=1, wr_addr=0, wr_data=blank_code; the first clear write occurs on the first cycle after reset deasserts.
REQ-032 Reset asserted mid-CLEAR or mid-ACCEPT SHALL restart CLEAR from address 0; no partial state is retained.

Verification
REQ-033 Reset then idle (num_cols=4, num_rows=2): 8 consecutive writes of blank_code to addresses 0..7, busy=1 throughout; then busy=0, c_ready=1.
REQ-034 After clear, stream 'A','B','C' on consecutive cycles: writes (0,'A'),(1,'B'),(2,'C') each one cycle after acceptance; cursor ends at (3,0).
REQ-035 Write 5 printable characters from (0,0) with num_cols=4: fifth write lands at address 4; cursor ends at col=1, row=1.
REQ-036 Send newline at (2,1) with num_rows=2: no wr_en pulse; cursor becomes (0,0).
REQ-037 Assert reset on cycle 3 of CLEAR: clearing restarts at address 0, and all num_cols*num_rows writes occur before c_ready rises.
REQ-038 Hold c_valid=0 for 10 cycles in ACCEPT: wr_en stays 0 and the cursor is unchanged.
